// File: rtl/lsu_mm_seq.sv
// -----------------------------------------------------------------------------
// lsu_mm_seq -- matmul tile sequencer for the WRAM / IRAM operand buffers.
//
// This block accepts one matmul command and splits it along K into 1..16 tiles.
// For each tile it sends one start pulse to both operand buffers. The pulse
// carries the row length, the column length and the start address. The block
// then waits for an end-of-stream from both buffers before it issues the next
// tile. It marks MXU accumulator clear (tile 0) and the last tile, and it
// pulses seq_done when the whole command has finished.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   seq_cmd_*                command handshake (vld/rdy) and command fields
//   seq_wram_ctrl_*          start pulse + row/col length + start address to WRAM
//   seq_iram_ctrl_*          start pulse + row/col length + start address to IRAM
//   seq_wram_end/iram_end    end-of-stream pulses from the buffers
//   seq_mxu_acc_clr          pulse with the tile-0 start pulse
//   seq_mxu_acc_last         level from the last tile's issue through done
//   seq_busy, seq_done       status
//
// Every output comes straight from a flop. Each output flop is loaded from the
// decode of the next state, so the outputs line up with the state register and
// no input reaches an output through combinational logic alone.
// -----------------------------------------------------------------------------
module lsu_mm_seq #(
  parameter logic [11:0] WRAM_STRIDE = 12'h100,
  parameter logic [11:0] IRAM_STRIDE = 12'h010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seq_cmd_vld,
  output logic        seq_cmd_rdy,
  input  logic [11:0] seq_cmd_wram_addr,
  input  logic [11:0] seq_cmd_iram_addr,
  input  logic [3:0]  seq_cmd_tile_cnt,
  input  logic [3:0]  seq_cmd_row_len,
  input  logic [3:0]  seq_cmd_col_len,
  output logic        seq_wram_ctrl_vld,
  output logic [3:0]  seq_wram_ctrl_row_len,
  output logic [3:0]  seq_wram_ctrl_col_len,
  output logic [11:0] seq_wram_ctrl_start_addr,
  output logic        seq_iram_ctrl_vld,
  output logic [3:0]  seq_iram_ctrl_row_len,
  output logic [3:0]  seq_iram_ctrl_col_len,
  output logic [11:0] seq_iram_ctrl_start_addr,
  input  logic        seq_wram_end,
  input  logic        seq_iram_end,
  output logic        seq_mxu_acc_clr,
  output logic        seq_mxu_acc_last,
  output logic        seq_busy,
  output logic        seq_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  tile_idx_q, tile_idx_d;
  logic [3:0]  tile_cnt_q, tile_cnt_d;
  logic [3:0]  row_len_q, row_len_d;
  logic [3:0]  col_len_q, col_len_d;
  logic        wram_seen_q, wram_seen_d;
  logic        iram_seen_q, iram_seen_d;

  // Output flops. Both buffers always receive the same pulse and lengths, so
  // each of these values is held in a single flop.
  logic        ctrl_vld_q, ctrl_vld_d;
  logic [3:0]  ctrl_row_q, ctrl_row_d;
  logic [3:0]  ctrl_col_q, ctrl_col_d;
  // The address outputs also act as the running per-tile address. The value
  // base + idx*stride is formed by adding the stride once at each issue.
  logic [11:0] wram_addr_q, wram_addr_d;
  logic [11:0] iram_addr_q, iram_addr_d;
  logic        acc_clr_q, acc_clr_d;
  logic        acc_last_q, acc_last_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;

  logic        issue_go;   // next cycle is an ISSUE cycle
  logic        both_ends;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    tile_cnt_d  = tile_cnt_q;
    row_len_d   = row_len_q;
    col_len_d   = col_len_q;
    wram_seen_d = wram_seen_q;
    iram_seen_d = iram_seen_q;
    wram_addr_d = wram_addr_q;
    iram_addr_d = iram_addr_q;
    ctrl_row_d  = ctrl_row_q;
    ctrl_col_d  = ctrl_col_q;
    issue_go    = 1'b0;
    // An end pulse counts if it arrives now or if it was seen earlier in this WAIT.
    both_ends   = (wram_seen_q | seq_wram_end) & (iram_seen_q | seq_iram_end);

    case (state_q)
      S_IDLE: begin
        if (seq_cmd_vld && rdy_q) begin
          tile_cnt_d  = seq_cmd_tile_cnt;
          row_len_d   = seq_cmd_row_len;
          col_len_d   = seq_cmd_col_len;
          tile_idx_d  = 4'd0;
          wram_addr_d = seq_cmd_wram_addr;
          iram_addr_d = seq_cmd_iram_addr;
          state_d     = S_ISSUE;
          issue_go    = 1'b1;
        end
      end
      S_ISSUE: begin
        wram_seen_d = 1'b0;
        iram_seen_d = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        wram_seen_d = wram_seen_q | seq_wram_end;
        iram_seen_d = iram_seen_q | seq_iram_end;
        if (both_ends) begin
          if (tile_idx_q == tile_cnt_q) begin
            state_d = S_DONE;
          end else begin
            tile_idx_d  = tile_idx_q + 4'd1;
            wram_addr_d = wram_addr_q + WRAM_STRIDE;   // wraps modulo 4096
            iram_addr_d = iram_addr_q + IRAM_STRIDE;
            state_d     = S_ISSUE;
            issue_go    = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Decode the registered outputs from the next state.
    ctrl_vld_d = issue_go;
    acc_clr_d  = issue_go && (tile_idx_d == 4'd0);
    if (issue_go) begin
      // Only the last tile is partial. Every earlier tile uses full 16x16 lengths.
      ctrl_row_d = (tile_idx_d == tile_cnt_d) ? row_len_d : 4'hF;
      ctrl_col_d = (tile_idx_d == tile_cnt_d) ? col_len_d : 4'hF;
    end
    rdy_d      = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    acc_last_d = (state_d != S_IDLE) && (tile_idx_d == tile_cnt_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge no matter how the statements are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tile_idx_q  <= 4'd0;
      tile_cnt_q  <= 4'd0;
      row_len_q   <= 4'd0;
      col_len_q   <= 4'd0;
      wram_seen_q <= 1'b0;
      iram_seen_q <= 1'b0;
      ctrl_vld_q  <= 1'b0;
      ctrl_row_q  <= 4'd0;
      ctrl_col_q  <= 4'd0;
      wram_addr_q <= 12'h000;
      iram_addr_q <= 12'h000;
      acc_clr_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      tile_cnt_q  <= tile_cnt_d;
      row_len_q   <= row_len_d;
      col_len_q   <= col_len_d;
      wram_seen_q <= wram_seen_d;
      iram_seen_q <= iram_seen_d;
      ctrl_vld_q  <= ctrl_vld_d;
      ctrl_row_q  <= ctrl_row_d;
      ctrl_col_q  <= ctrl_col_d;
      wram_addr_q <= wram_addr_d;
      iram_addr_q <= iram_addr_d;
      acc_clr_q   <= acc_clr_d;
      acc_last_q  <= acc_last_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
    end
  end

  assign seq_cmd_rdy              = rdy_q;
  assign seq_wram_ctrl_vld        = ctrl_vld_q;
  assign seq_wram_ctrl_row_len    = ctrl_row_q;
  assign seq_wram_ctrl_col_len    = ctrl_col_q;
  assign seq_wram_ctrl_start_addr = wram_addr_q;
  assign seq_iram_ctrl_vld        = ctrl_vld_q;
  assign seq_iram_ctrl_row_len    = ctrl_row_q;
  assign seq_iram_ctrl_col_len    = ctrl_col_q;
  assign seq_iram_ctrl_start_addr = iram_addr_q;
  assign seq_mxu_acc_clr          = acc_clr_q;
  assign seq_mxu_acc_last         = acc_last_q;
  assign seq_busy                 = busy_q;
  assign seq_done                 = done_q;

endmodule

// File: doc/lsu_mm_seq.md
# lsu_mm_seq

Matmul tile sequencer in the LSU, directly upstream of the WRAM and IRAM matmul operand buffers. It accepts one matmul command and splits it along the K dimension into 1–16 tiles. For each tile it issues one start pulse, with row length, column length and start address, to both operand buffers. It then waits for both buffers to report end-of-stream before issuing the next tile. It also marks MXU accumulator clear and last-tile boundaries, and reports command completion.

## Interface
Parameters:
- WRAM_STRIDE, 12'h100, byte-address increment of the WRAM start address per tile (16 rows × 16 B).
- IRAM_STRIDE, 12'h010, byte-address increment of the IRAM start address per tile (one 16 B column block).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- seq_cmd_vld  in  1  command valid.
- seq_cmd_rdy  out  1  command ready; the command is accepted on the cycle where vld & rdy.
- seq_cmd_wram_addr  in  12  WRAM base byte address.
- seq_cmd_iram_addr  in  12  IRAM base byte address.
- seq_cmd_tile_cnt  in  4  number of tiles minus 1 (0 → 1 tile, 15 → 16 tiles).
- seq_cmd_row_len  in  4  row length minus 1 for the last tile.
- seq_cmd_col_len  in  4  column length minus 1 for the last tile.
- seq_wram_ctrl_vld  out  1  one-cycle start pulse to the WRAM buffer.
- seq_wram_ctrl_row_len  out  4  row length field to the WRAM buffer.
- seq_wram_ctrl_col_len  out  4  column length field to the WRAM buffer.
- seq_wram_ctrl_start_addr  out  12  start byte address to the WRAM buffer.
- seq_iram_ctrl_vld  out  1  one-cycle start pulse to the IRAM buffer.
- seq_iram_ctrl_row_len  out  4  row length field to the IRAM buffer.
- seq_iram_ctrl_col_len  out  4  column length field to the IRAM buffer.
- seq_iram_ctrl_start_addr  out  12  start byte address to the IRAM buffer.
- seq_wram_end  in  1  end-of-stream pulse from the WRAM buffer.
- seq_iram_end  in  1  end-of-stream pulse from the IRAM buffer.
- seq_mxu_acc_clr  out  1  pulse coincident with the tile-0 start pulse; the MXU clears its accumulators.
- seq_mxu_acc_last  out  1  level, high from the last tile's ISSUE cycle through the DONE cycle.
- seq_busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle pulse when the command completes.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE. All outputs are decoded from registered state, so there are no combinational paths from inputs to outputs.
- IDLE
  - seq_cmd_rdy = 1.
  - On vld & rdy: latch the address, count and length fields, set tile_idx = 0, and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - seq_wram_ctrl_vld = seq_iram_ctrl_vld = 1.
  - WRAM start_addr = wram_base + tile_idx × WRAM_STRIDE. IRAM start_addr = iram_base + tile_idx × IRAM_STRIDE.
  - Address arithmetic is 12-bit, modulo 4096; wrap is silent.
  - row_len and col_len = latched values when tile_idx == tile_cnt; otherwise 4'hF.
  - seq_mxu_acc_clr = (tile_idx == 0).
  - Clear both end-seen flags, then go to WAIT.
- WAIT
  - Set wram_seen on seq_wram_end and iram_seen on seq_iram_end. The flags are sticky; the two ends may arrive in any order or in the same cycle.
  - When (wram_seen | seq_wram_end) & (iram_seen | seq_iram_end):
    - if tile_idx == tile_cnt, go to DONE;
    - otherwise increment tile_idx and go to ISSUE.
- DONE (1 cycle): seq_done = 1, then go to IDLE.
- End pulses received in IDLE, ISSUE or DONE are ignored and do not set the flags.
- A second end pulse from the same buffer within one WAIT has no additional effect.
- While busy, the seq_cmd_* inputs are ignored; there is no queuing.
- Reset mid-operation: the next cycle is IDLE, tile_idx and both flags are 0, and no further ctrl pulses are issued.

## Timing
- Reset values: seq_cmd_rdy = 1. All other outputs = 0, including addresses and length fields. Registered fields and tile_idx = 0.
- Command accepted in cycle N → first ctrl pulses in cycle N+1.
- Last required end pulse in cycle E:
  - non-last tile: next ISSUE in cycle E+1;
  - last tile: seq_done in cycle E+1 and seq_cmd_rdy = 1 in cycle E+2.
- The earliest new command acceptance is cycle E+2, so a back-to-back command has a 1-cycle bubble.
- Minimum tile period is 2 cycles (ISSUE, then WAIT with both ends arriving in the first WAIT cycle).
- ctrl_row_len, ctrl_col_len and ctrl_start_addr hold their last-issued values outside ISSUE.

## Test plan
- Single tile: cmd with wram 12'h000, iram 12'h040, tile_cnt 0, row 3, col 5; ends return together 4 cycles after ISSUE.
  - Expect one pulse on each ctrl port with row 3, col 5 and addrs 0x000 / 0x040.
  - Expect acc_clr and acc_last in the ISSUE cycle, and done exactly 1 cycle after the ends.
- Four tiles, tile_cnt 3, wram 12'h100, iram 12'h000:
  - WRAM addrs 0x100, 0x200, 0x300, 0x400; IRAM addrs 0x000, 0x010, 0x020, 0x030.
  - Lengths are F/F on tiles 0–2 and the command values on tile 3.
  - acc_clr only on tile 0.
- Staggered ends: WRAM end 2 cycles after ISSUE, IRAM end 7 cycles after ISSUE → next ISSUE exactly 1 cycle after the IRAM end. Repeat with the order swapped.
- Wrap and stray ends: wram 12'hF00, tile_cnt 1 → second WRAM addr 0x000. An end pulse injected in the ISSUE cycle and in IDLE must not advance the sequence.
- Handshake: hold cmd_vld high through a 2-tile command → exactly one accept (rdy low while busy). A second command is accepted 2 cycles after the first command's last end pulse.
- Reset mid-WAIT of tile 2 of 5:
  - Next cycle: rdy = 1, busy = 0, no ctrl pulses.
  - A fresh single-tile command then completes normally with tile_idx starting at 0.
